pdm_mic_ctrl: RTL

Sequencer and stream scheduler placed after the dual-channel PDM mic decimator (audio1/audio2/audio_valid).
- Gates the decimator/mic clock enable and discards start-up samples while the mic settles.
- Serialises the two per-sample channel words into one tagged valid/ready stream through a small FIFO for downstream consumers (audio DSP or bus readout).
- Reports state and overflow.

---
 rtl/pdm_mic_pkg.sv | 23 ++
 rtl/pdm_sample_fifo.sv | 58 +++++
 rtl/pdm_mic_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pdm_mic_pkg.sv
// Shared definitions for the PDM mic controller: sequencer states,
// channel tags and FIFO entry sizing ({channel tag, sample}).
package pdm_mic_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } mic_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_SAMPLE_DEPTH = 16;
    localparam int FIFO_ENTRY_W         = DEFAULT_SAMPLE_DEPTH + 1;

    // Entry width for an arbitrary sample width: one tag bit above the sample.
    function automatic int fifo_entry_w(input int sample_depth);
        return sample_depth + 1;
    endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// First-word-fall-through FIFO. The head entry is read combinationally from
// registered storage; the read port shows zero while empty. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module pdm_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM mic sequencer: powers the mic/decimator, throws away start-up samples,
// then splits each sample pair into two tagged FIFO writes (channel 0 on the
// strobe edge "slot A", channel 1 on the following edge "slot B").
// Optional build macro PDM_MIC_CTRL_STATS_EN adds a saturating drop counter.
module pdm_mic_ctrl
    import pdm_mic_pkg::*;
#(
    parameter int SAMPLE_DEPTH   = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int SETTLE_SAMPLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_enable,
    input  logic [1:0]                            cfg_chan_mask,
    output logic                                  mic_en,
    input  logic signed [SAMPLE_DEPTH-1:0]        mic_audio1,
    input  logic signed [SAMPLE_DEPTH-1:0]        mic_audio2,
    input  logic                                  mic_audio_valid,
    output logic signed [SAMPLE_DEPTH-1:0]        out_data,
    output logic                                  out_chan,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow,
    input  logic                                  overflow_clr,
    output logic [1:0]                            state,
`ifdef PDM_MIC_CTRL_STATS_EN
    output logic [15:0]                           drop_count,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);

    localparam int ENTRY_W = fifo_entry_w(SAMPLE_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_SAMPLES);

    mic_state_e                      state_q;
    mic_state_e                      state_d;
    logic [CNT_W-1:0]                settle_cnt;
    logic                            slot_a;
    logic                            slot_b_vld_p1;
    logic signed [SAMPLE_DEPTH-1:0]  audio2_p1;
    logic                            mask1_p1;
    logic                            push;
    logic [ENTRY_W-1:0]              wdata;
    logic                            pop;
    logic                            drop;
    logic [ENTRY_W-1:0]              fifo_rdata;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [LVL_W-1:0]                fifo_lvl;

    assign state      = state_q;
    assign out_valid  = !fifo_empty;
    assign out_chan   = fifo_rdata[SAMPLE_DEPTH];
    assign out_data   = fifo_rdata[SAMPLE_DEPTH-1:0];
    assign fifo_level = fifo_lvl;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_OFF;
        else     state_q <= state_d;
    end

    // Next-state logic; DRAIN waits for a pending slot B as well as an empty FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:    if (cfg_enable) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!cfg_enable)           state_d = ST_DRAIN;
                else if (settle_cnt == '0) state_d = ST_RUN;
            end
            ST_RUN:    if (!cfg_enable) state_d = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty && !slot_b_vld_p1) state_d = ST_OFF;
            default:   state_d = ST_OFF;
        endcase
    end

    // Output logic: slot sequencing and FIFO write/pop requests.
    always_comb begin
        slot_a = (state_q == ST_RUN) && mic_audio_valid && !slot_b_vld_p1;
        push   = 1'b0;
        wdata  = '0;
        if (slot_b_vld_p1) begin
            push  = mask1_p1;
            wdata = {CH1, audio2_p1};
        end else if (slot_a) begin
            push  = cfg_chan_mask[0];
            wdata = {CH0, mic_audio1};
        end
        pop  = out_valid && out_ready;
        drop = push && fifo_full && !pop;
    end

    // mic_en is a clean register that tracks the state it is entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mic_en <= 1'b0;
        else     mic_en <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
    end

    // Settle counter: loaded on enable, counts down discarded strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state_q == ST_OFF && cfg_enable) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state_q == ST_SETTLE && mic_audio_valid && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    // Slot B pending flag; set by every slot A, cleared the edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_b_vld_p1 <= 1'b0;
        else     slot_b_vld_p1 <= slot_a;
    end

    // Channel 1 sample and its mask bit, held from slot A for slot B.
    always_ff @(posedge clk) begin
        if (slot_a) begin
            audio2_p1 <= mic_audio2;
            mask1_p1  <= cfg_chan_mask[1];
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

`ifdef PDM_MIC_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Dropped-sample counter; clear and drop together restart the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               drop_count <= '0;
        else if (drop)         drop_count <= overflow_clr ? 16'd1 : sat_inc16(drop_count);
        else if (overflow_clr) drop_count <= '0;
    end
`endif

    pdm_sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

endmodule
